lcd_cmd_sched: RTL and testbench
================================

# lcd_cmd_sched

Command scheduler in front of the LCD image-processing engine. It buffers host commands in a small FIFO and issues them one at a time on the engine's `cmd`/`cmd_valid` port, only while the engine is idle (`busy` low). It also tracks the final write-out command through to the engine's `done`. It sits between the testbench/host command source and the LCD controller, and is the only driver of the engine's command inputs.

## Interface
**Parameters**
- `DEPTH`, default 8: FIFO entries. Must be a power of two, ≥2.
- `CNT_W`, default 8: width of the issued-command counter.

**Ports**
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `host_cmd` input 4: command code from the host. 0 = write-out; 1–11 = engine ops; 12–15 = illegal.
- `host_valid` input 1: host command valid.
- `host_ready` output 1: scheduler can accept; transfer occurs when `host_valid & host_ready`.
- `cmd` output 4: command to the engine.
- `cmd_valid` output 1: one-cycle issue strobe to the engine.
- `busy` input 1: engine busy.
- `done` input 1: engine write-out complete.
- `seq_done` output 1: sticky; engine reported `done` after write-out.
- `err_illegal` output 1: sticky; an illegal code was seen.
- `issued_cnt` output `CNT_W`: number of commands issued, saturating.

## Operation
- Reset values: `host_ready`=0, `cmd`=0, `cmd_valid`=0, `seq_done`=0, `err_illegal`=0, `issued_cnt`=0. FIFO is empty; state is INIT.
- **FIFO**
  - Circular buffer with `DEPTH` entries and pointer width log2(`DEPTH`)+1 for full/empty detection.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- **`host_ready`** = !full & !sealed & state≠INIT. `sealed` is set when code 0 is accepted and is cleared only by reset; later pushes are refused.
- **States**
  - INIT: wait for `busy`=0; the engine holds `busy` high while loading its ROM. Then go to IDLE.
  - IDLE: if the FIFO is non-empty and `busy`=0, pop the head, register `cmd`=head and `cmd_valid`=1, and go to ISSUE.
  - ISSUE: `cmd_valid` returns to 0. Increment `issued_cnt` (saturating at all-ones). If the issued code was 0, go to FLUSH; else go to HOLD.
  - HOLD: one cycle in which `busy` is ignored, covering the engine's one-cycle OP latency. Go to WAIT.
  - WAIT: when `busy`=0, go to IDLE.
  - FLUSH: when `done`=1, set `seq_done` and go to END.
  - END: terminal until reset. No issues.
- `cmd` holds its last issued value between strobes.
- Illegal codes 12–15 are handled according to Configuration.
- Reset mid-operation: all state, FIFO contents, sticky flags and the counter clear immediately (asynchronous). A `cmd_valid` pulse in flight is cut.

## Timing
- Host handshake in cycle t with FIFO empty, state IDLE and `busy`=0 → `cmd_valid`=1 in cycle t+2.
- `cmd_valid` is high for exactly one cycle per issued command and never in consecutive cycles.
- Minimum issue spacing is 4 cycles: ISSUE, HOLD, WAIT (seeing `busy`=0), IDLE.
- `seq_done` rises the cycle after `done` is sampled high in FLUSH.
- `done` outside FLUSH is ignored.
- `busy` high in IDLE stalls issue indefinitely; FIFO contents are retained.

## Configuration
- **`LCD_SCHED_ILLEGAL_FILTER_EN` defined:**
  - Codes 12–15 are accepted at the host port (`host_ready` behaves normally) but discarded without being written to the FIFO.
  - `err_illegal` sets the cycle after the handshake.
  - `issued_cnt` is unaffected.
- **`LCD_SCHED_ILLEGAL_FILTER_EN` undefined:**
  - Codes 12–15 are queued and issued unchanged; the engine treats them as no-ops.
  - `err_illegal` sets in the cycle the code is issued; `issued_cnt` increments.

## Test plan
- Reset, hold `busy`=1 for 70 cycles then drop it → `host_ready` stays 0 until the cycle after `busy` falls; all outputs are 0 throughout.
- Push 1, 4, 5 back-to-back while the engine model pulses `busy` for one cycle per command → three `cmd_valid` strobes carrying 1, 4, 5, each ≥4 cycles apart; `issued_cnt`=3.
- Hold `busy`=1 and push 9 commands with `DEPTH`=8 → 8 accepted, `host_ready`=0 on the 9th. Drop `busy` → 8 strobes in FIFO order. Simultaneous push/pop keeps occupancy constant.
- Push 7, then 0, then 3 → 3 is refused (`host_ready`=0 after 0 is accepted). 0 is issued, the scheduler waits in FLUSH; `done` pulse → `seq_done`=1 next cycle, no further strobes.
- Push 13 → filter build: no strobe, `err_illegal`=1, `issued_cnt` unchanged. Non-filter build: strobe with `cmd`=13, `err_illegal`=1, `issued_cnt`+1.
- Assert `reset` in the HOLD state with 3 entries queued → all outputs 0 immediately; after release, no stale commands are issued.

Source files
------------

// File: rtl/lcd_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_sched
// Purpose  : Buffers host commands and issues them one at a time to the LCD
//            engine while it is idle; tracks write-out through to done.
// Options  : LCD_SCHED_ILLEGAL_FILTER_EN - drop codes 12-15 at the host port
// Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_sched #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       host_cmd,
    input  logic             host_valid,
    output logic             host_ready,
    output logic [3:0]       cmd,
    output logic             cmd_valid,
    input  logic             busy,
    input  logic             done,
    output logic             seq_done,
    output logic             err_illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4,
        S_FLUSH = 3'd5,
        S_END   = 3'd6
    } state_t;

    state_t             r_state;
    logic [3:0]         r_mem [DEPTH];
    logic [c_ADDR_W:0]  r_wr_ptr;
    logic [c_ADDR_W:0]  r_rd_ptr;
    logic               r_sealed;
    logic [3:0]         r_cmd;
    logic               r_cmd_valid;
    logic               r_seq_done;
    logic               r_err_illegal;
    logic [CNT_W-1:0]   r_issued_cnt;

    logic               w_empty;
    logic               w_full;
    logic               w_host_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_err_set;
    logic [3:0]         w_head;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                          (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_host_ready = !w_full && !r_sealed && (r_state != S_INIT);
    assign w_accept     = host_valid && w_host_ready;
    assign w_head       = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign w_pop        = (r_state == S_IDLE) && !w_empty && !busy;

`ifdef LCD_SCHED_ILLEGAL_FILTER_EN
    logic w_in_illegal;
    assign w_in_illegal = (host_cmd[3:2] == 2'b11);
    assign w_push       = w_accept && !w_in_illegal;
    assign w_err_set    = w_accept && w_in_illegal;
`else
    logic w_head_illegal;
    assign w_head_illegal = (w_head[3:2] == 2'b11);
    assign w_push         = w_accept;
    assign w_err_set      = w_pop && w_head_illegal;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_sealed <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 4'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= host_cmd;
                r_wr_ptr <= r_wr_ptr + (c_ADDR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_ADDR_W+1)'(1);
            end
            // Write-out is the last command of a sequence; refuse anything after it
            if (w_accept && (host_cmd == 4'd0)) begin
                r_sealed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_INIT;
            r_cmd         <= 4'd0;
            r_cmd_valid   <= 1'b0;
            r_seq_done    <= 1'b0;
            r_err_illegal <= 1'b0;
            r_issued_cnt  <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            if (w_err_set) begin
                r_err_illegal <= 1'b1;
            end
            case (r_state)
                S_INIT: begin
                    if (!busy) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_pop) begin
                        r_cmd       <= w_head;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_issued_cnt != {CNT_W{1'b1}}) begin
                        r_issued_cnt <= r_issued_cnt + CNT_W'(1);
                    end
                    r_state <= (r_cmd == 4'd0) ? S_FLUSH : S_HOLD;
                end
                // Engine raises busy one cycle late, so busy is not trusted here
                S_HOLD: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!busy) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (done) begin
                        r_seq_done <= 1'b1;
                        r_state    <= S_END;
                    end
                end
                S_END: begin
                    r_state <= S_END;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign host_ready  = w_host_ready;
    assign cmd         = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign seq_done    = r_seq_done;
    assign err_illegal = r_err_illegal;
    assign issued_cnt  = r_issued_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_cmd_sched
// Purpose  : Directed self-checking bench for lcd_cmd_sched with a command
//            scoreboard; honours LCD_SCHED_ILLEGAL_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_cmd_sched;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       host_cmd = 4'd0;
    logic             host_valid = 1'b0;
    logic             host_ready;
    logic [3:0]       cmd;
    logic             cmd_valid;
    logic             busy;
    logic             busy_force = 1'b1;
    logic             model_busy = 1'b0;
    logic             done = 1'b0;
    logic             seq_done;
    logic             err_illegal;
    logic [CNT_W-1:0] issued_cnt;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_strobe = -100;
    int         strobes = 0;
    int         exp_issued = 0;
    int         s0;
    logic [3:0] exp_q[$];

    lcd_cmd_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .seq_done   (seq_done),
        .err_illegal(err_illegal),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    // Engine model: busy for one cycle following each issue strobe
    always @(posedge clk) model_busy <= cmd_valid;
    assign busy = busy_force | model_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (cmd_valid === 1'b1) begin
            strobes++;
            check("strobe_spacing", 32'(cyc - last_strobe >= 4), 32'd1);
            last_strobe = cyc;
            check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("strobe_cmd", 32'(cmd), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c);
        int n = 0;
        host_cmd   = c;
        host_valid = 1'b1;
        @(negedge clk);
        while (host_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(host_ready), 32'd1);
        step();
        if (n < 200) begin
`ifdef LCD_SCHED_ILLEGAL_FILTER_EN
            if (c < 4'd12) begin
                exp_q.push_back(c);
                exp_issued++;
            end
`else
            exp_q.push_back(c);
            exp_issued++;
`endif
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and ROM-load phase
        repeat (3) step();
        @(negedge clk);
        check("rst_outputs", {host_ready, cmd, cmd_valid, seq_done, err_illegal, issued_cnt}, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            check("init_ready", 32'(host_ready), 32'd0);
            check("init_outputs", {cmd, cmd_valid, seq_done, err_illegal, issued_cnt}, 32'd0);
        end
        step();
        busy_force = 1'b0;
        @(negedge clk);
        check("init_busy_fall_ready", 32'(host_ready), 32'd0);
        @(negedge clk);
        check("init_after_ready", 32'(host_ready), 32'd1);
        step();

        // Handshake-to-issue latency
        push(4'd2);
        host_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_valid", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        check("lat_t2_valid", 32'(cmd_valid), 32'd1);
        check("lat_t2_cmd", 32'(cmd), 32'd2);
        drain();
        check("cmd_hold", 32'(cmd), 32'd2);

        // done outside FLUSH is ignored
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (3) step();
        check("done_ignored", 32'(seq_done), 32'd0);

        // Back-to-back pushes
        push(4'd1);
        push(4'd4);
        push(4'd5);
        host_valid = 1'b0;
        drain();
        check("cnt_after_145", 32'(issued_cnt), 32'(exp_issued));

        // Fill while stalled, then simultaneous push/pop
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(4'(i + 2));
        host_cmd = 4'd10;
        @(negedge clk);
        check("full_refuse", 32'(host_ready), 32'd0);
        step();
        host_valid = 1'b0;
        busy_force = 1'b0;
        step();
        busy_force = 1'b1;
        repeat (3) step();
        busy_force = 1'b0;
        step();
        host_cmd   = 4'd11;
        host_valid = 1'b1;
        @(negedge clk);
        check("simul_ready", 32'(host_ready), 32'd1);
        step();
        exp_q.push_back(4'd11);
        exp_issued++;
        host_valid = 1'b0;
        busy_force = 1'b1;
        push(4'd6);
        host_valid = 1'b0;
        @(negedge clk);
        check("refill_full", 32'(host_ready), 32'd0);
        busy_force = 1'b0;
        drain();
        check("cnt_after_fill", 32'(issued_cnt), 32'(exp_issued));

        // Illegal code
        check("err_before", 32'(err_illegal), 32'd0);
        push(4'd13);
        host_valid = 1'b0;
`ifdef LCD_SCHED_ILLEGAL_FILTER_EN
        @(negedge clk);
        check("err_filter_set", 32'(err_illegal), 32'd1);
`else
        @(negedge clk);
        check("err_not_yet", 32'(err_illegal), 32'd0);
        @(negedge clk);
        check("illegal_strobe", 32'(cmd_valid), 32'd1);
        check("illegal_cmd", 32'(cmd), 32'd13);
        check("err_with_issue", 32'(err_illegal), 32'd1);
`endif
        drain();
        check("cnt_after_illegal", 32'(issued_cnt), 32'(exp_issued));

        // Reset in HOLD with entries queued
        busy_force = 1'b1;
        push(4'd1);
        push(4'd2);
        push(4'd3);
        push(4'd4);
        host_valid = 1'b0;
        busy_force = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("midrst_outputs", {host_ready, cmd, cmd_valid, seq_done, err_illegal, issued_cnt}, 32'd0);
        exp_q.delete();
        exp_issued = 0;
        step();
        reset = 1'b0;
        s0 = strobes;
        repeat (30) step();
        check("no_stale_strobes", 32'(strobes - s0), 32'd0);
        check("cnt_after_rst", 32'(issued_cnt), 32'd0);
        check("ready_after_rst", 32'(host_ready), 32'd1);

        // Write-out seals the queue and waits for done
        push(4'd7);
        push(4'd0);
        host_cmd = 4'd3;
        @(negedge clk);
        check("sealed_refuse", 32'(host_ready), 32'd0);
        host_valid = 1'b0;
        drain();
        check("flush_no_done", 32'(seq_done), 32'd0);
        check("cnt_after_seal", 32'(issued_cnt), 32'(exp_issued));
        s0 = strobes;
        done = 1'b1;
        @(negedge clk);
        check("seq_done_same_cycle", 32'(seq_done), 32'd0);
        step();
        done = 1'b0;
        @(negedge clk);
        check("seq_done_rise", 32'(seq_done), 32'd1);
        host_cmd   = 4'd5;
        host_valid = 1'b1;
        repeat (20) step();
        host_valid = 1'b0;
        check("end_no_strobes", 32'(strobes - s0), 32'd0);
        check("end_ready", 32'(host_ready), 32'd0);
        check("seq_done_sticky", 32'(seq_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
